layer2_neuron_ctrl: RTL and testbench

LAYER2_NEURON_CTRL -- requirements
Module: layer2_neuron_ctrl

---
 rtl/layer2_neuron_ctrl.sv | 151 +++++++++++++++
 tb/tb_layer2_neuron_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/layer2_neuron_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : layer2_neuron_ctrl
// Brief    : Per-timestep sequencer for the layer-2 neuron set (update, spike,
//            optional surrogate sweep, sample done).
// Revision : 1.0 - initial release
// ============================================================================
module layer2_neuron_ctrl #(
    parameter int BIT_WIDTH_SURROGATE = 3,
    parameter int TIMESTEP_BITS       = 8
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           sample_start_i,
    input  logic [TIMESTEP_BITS-1:0]       num_timesteps_i,
    input  logic                           training_state_i,
    input  logic                           accum_done_i,
    output logic                           membrane_update_valid_o,
    output logic                           post_spiking_now_o,
    output logic                           surrogate_compute_time_o,
    output logic [BIT_WIDTH_SURROGATE-1:0] surrogate_ref_o,
    output logic                           surrogate_read_finish_o,
    output logic                           this_sample_done_o,
    output logic                           training_state_o,
    output logic [TIMESTEP_BITS-1:0]       timestep_o,
    output logic                           busy_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCUM  = 3'd1,
        S_UPDATE = 3'd2,
        S_SPIKE  = 3'd3,
        S_SURR   = 3'd4,
        S_FIN    = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    localparam logic [TIMESTEP_BITS-1:0]       c_ts_one    = {{(TIMESTEP_BITS-1){1'b0}}, 1'b1};
    localparam logic [BIT_WIDTH_SURROGATE-1:0] c_surr_one  = {{(BIT_WIDTH_SURROGATE-1){1'b0}}, 1'b1};
    localparam logic [BIT_WIDTH_SURROGATE-1:0] c_surr_last = '1;

    state_t                           r_state;
    logic [TIMESTEP_BITS-1:0]         r_count;
    logic                             r_train;
    logic [TIMESTEP_BITS-1:0]         r_timestep;
    logic [BIT_WIDTH_SURROGATE-1:0]   r_surr;

    state_t                           w_next_state;
    logic [TIMESTEP_BITS-1:0]         w_next_count;
    logic                             w_next_train;
    logic [TIMESTEP_BITS-1:0]         w_next_timestep;
    logic [BIT_WIDTH_SURROGATE-1:0]   w_next_surr;
    logic                             w_last;

    // The count is never below 1, so count-1 cannot underflow during a sample.
    assign w_last = (r_timestep == (r_count - c_ts_one));

    always_comb begin
        w_next_state    = r_state;
        w_next_count    = r_count;
        w_next_train    = r_train;
        w_next_timestep = r_timestep;
        w_next_surr     = '0;
        case (r_state)
            S_IDLE: begin
                if (sample_start_i) begin
                    w_next_state    = S_ACCUM;
                    w_next_count    = (num_timesteps_i == '0) ? c_ts_one : num_timesteps_i;
                    w_next_train    = training_state_i;
                    w_next_timestep = '0;
                end
            end
            S_ACCUM: begin
                if (accum_done_i) begin
                    w_next_state = S_UPDATE;
                end
            end
            S_UPDATE: begin
                w_next_state = S_SPIKE;
            end
            S_SPIKE: begin
                if (r_train) begin
                    w_next_state = S_SURR;
                end else if (w_last) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state    = S_ACCUM;
                    w_next_timestep = r_timestep + c_ts_one;
                end
            end
            S_SURR: begin
                if (r_surr == c_surr_last) begin
                    w_next_state = S_FIN;
                end else begin
                    w_next_surr = r_surr + c_surr_one;
                end
            end
            S_FIN: begin
                if (w_last) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state    = S_ACCUM;
                    w_next_timestep = r_timestep + c_ts_one;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Strobes are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state                  <= S_IDLE;
            r_count                  <= '0;
            r_train                  <= 1'b0;
            r_timestep               <= '0;
            r_surr                   <= '0;
            membrane_update_valid_o  <= 1'b0;
            post_spiking_now_o       <= 1'b0;
            surrogate_compute_time_o <= 1'b0;
            surrogate_read_finish_o  <= 1'b0;
            this_sample_done_o       <= 1'b0;
            busy_o                   <= 1'b0;
        end else begin
            r_state                  <= w_next_state;
            r_count                  <= w_next_count;
            r_train                  <= w_next_train;
            r_timestep               <= w_next_timestep;
            r_surr                   <= w_next_surr;
            membrane_update_valid_o  <= (w_next_state == S_UPDATE);
            post_spiking_now_o       <= (w_next_state == S_SPIKE);
            surrogate_compute_time_o <= (w_next_state == S_SURR);
            surrogate_read_finish_o  <= (w_next_state == S_FIN);
            this_sample_done_o       <= (w_next_state == S_DONE);
            busy_o                   <= (w_next_state != S_IDLE);
        end
    end

    assign surrogate_ref_o  = r_surr;
    assign training_state_o = r_train;
    assign timestep_o       = r_timestep;

endmodule
`default_nettype wire

// File: tb/tb_layer2_neuron_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_layer2_neuron_ctrl
// Brief    : Scoreboard bench for layer2_neuron_ctrl; expected per-cycle output
//            vectors are queued by stimulus and popped by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_layer2_neuron_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       sample_start_i;
    logic [7:0] num_timesteps_i;
    logic       training_state_i;
    logic       accum_done_i;
    logic       membrane_update_valid_o;
    logic       post_spiking_now_o;
    logic       surrogate_compute_time_o;
    logic [2:0] surrogate_ref_o;
    logic       surrogate_read_finish_o;
    logic       this_sample_done_o;
    logic       training_state_o;
    logic [7:0] timestep_o;
    logic       busy_o;

    int compared   = 0;
    int mismatched = 0;
    logic [17:0] exp_q[$];

    layer2_neuron_ctrl #(
        .BIT_WIDTH_SURROGATE(3),
        .TIMESTEP_BITS      (8)
    ) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .sample_start_i          (sample_start_i),
        .num_timesteps_i         (num_timesteps_i),
        .training_state_i        (training_state_i),
        .accum_done_i            (accum_done_i),
        .membrane_update_valid_o (membrane_update_valid_o),
        .post_spiking_now_o      (post_spiking_now_o),
        .surrogate_compute_time_o(surrogate_compute_time_o),
        .surrogate_ref_o         (surrogate_ref_o),
        .surrogate_read_finish_o (surrogate_read_finish_o),
        .this_sample_done_o      (this_sample_done_o),
        .training_state_o        (training_state_o),
        .timestep_o              (timestep_o),
        .busy_o                  (busy_o)
    );

    always #5 clk = ~clk;

    // Vector layout: busy, update, spike, surr, ref[2:0], fin, done, train, timestep[7:0]
    logic [17:0] obs;
    assign obs = {busy_o, membrane_update_valid_o, post_spiking_now_o, surrogate_compute_time_o,
                  surrogate_ref_o, surrogate_read_finish_o, this_sample_done_o,
                  training_state_o, timestep_o};

    function automatic logic [17:0] mk(input logic busy, input logic upd, input logic spk,
                                       input logic sct, input logic [2:0] rf, input logic fin,
                                       input logic done, input logic trn, input logic [7:0] ts);
        return {busy, upd, spk, sct, rf, fin, done, trn, ts};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every cycle with any activity must match the head of the queue.
    always @(negedge clk) begin
        if (busy_o || membrane_update_valid_o || post_spiking_now_o || surrogate_compute_time_o ||
            surrogate_read_finish_o || this_sample_done_o || (surrogate_ref_o != 3'd0)) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_activity: got %h, expected no activity", obs);
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                if (obs !== e) begin
                    mismatched++;
                    $display("FAIL seq_vector @%0t: got %h, expected %h", $time, obs, e);
                end
            end
        end
    end

    // Assumes the caller is aligned to a falling edge; returns aligned to one with the DUT idle.
    task automatic run_sample(input int num, input bit train, input int d,
                              input bit inject, input bit change_cfg);
        int tcnt;
        int nwait;
        tcnt = (num == 0) ? 1 : num;
        for (int t = 0; t < tcnt; t++) begin
            for (int k = 0; k <= d; k++) exp_q.push_back(mk(1, 0, 0, 0, 3'd0, 0, 0, train, 8'(t)));
            exp_q.push_back(mk(1, 1, 0, 0, 3'd0, 0, 0, train, 8'(t)));
            exp_q.push_back(mk(1, 0, 1, 0, 3'd0, 0, 0, train, 8'(t)));
            if (train) begin
                for (int r = 0; r < 8; r++) exp_q.push_back(mk(1, 0, 0, 1, 3'(r), 0, 0, train, 8'(t)));
                exp_q.push_back(mk(1, 0, 0, 0, 3'd0, 1, 0, train, 8'(t)));
            end
            if (t == tcnt - 1) exp_q.push_back(mk(1, 0, 0, 0, 3'd0, 0, 1, train, 8'(t)));
        end
        sample_start_i   = 1'b1;
        num_timesteps_i  = 8'(num);
        training_state_i = train;
        @(negedge clk);
        sample_start_i = 1'b0;
        if (change_cfg) begin
            num_timesteps_i  = 8'd1;
            training_state_i = ~train;
        end
        for (int t = 0; t < tcnt; t++) begin
            repeat (d) @(negedge clk);
            accum_done_i = 1'b1;
            @(negedge clk);
            accum_done_i = 1'b0;
            nwait = 2 + (train ? 9 : 0) + ((t == tcnt - 1) ? 1 : 0);
            for (int i = 1; i <= nwait; i++) begin
                @(negedge clk);
                if (inject && t == 0 && i == 3) begin
                    sample_start_i = 1'b1;
                    accum_done_i   = 1'b1;
                end
                if (inject && t == 0 && i == 4) begin
                    sample_start_i = 1'b0;
                    accum_done_i   = 1'b0;
                end
            end
        end
    endtask

    task automatic reset_in_surr();
        exp_q.push_back(mk(1, 0, 0, 0, 3'd0, 0, 0, 1, 8'd0));
        exp_q.push_back(mk(1, 1, 0, 0, 3'd0, 0, 0, 1, 8'd0));
        exp_q.push_back(mk(1, 0, 1, 0, 3'd0, 0, 0, 1, 8'd0));
        for (int r = 0; r < 6; r++) exp_q.push_back(mk(1, 0, 0, 1, 3'(r), 0, 0, 1, 8'd0));
        sample_start_i   = 1'b1;
        num_timesteps_i  = 8'd2;
        training_state_i = 1'b1;
        @(negedge clk);
        sample_start_i = 1'b0;
        accum_done_i   = 1'b1;
        @(negedge clk);
        accum_done_i = 1'b0;
        repeat (7) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check("async_reset_outputs", 32'(obs), 32'd0);
        repeat (4) @(negedge clk);
        check("reset_held_no_done", 32'(obs), 32'd0);
        reset_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n          = 1'b0;
        sample_start_i   = 1'b0;
        num_timesteps_i  = 8'd0;
        training_state_i = 1'b0;
        accum_done_i     = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'(obs), 32'd0);
        sample_start_i   = 1'b1;
        accum_done_i     = 1'b1;
        training_state_i = 1'b1;
        num_timesteps_i  = 8'd5;
        repeat (2) @(negedge clk);
        check("reset_priority", 32'(obs), 32'd0);
        sample_start_i = 1'b0;
        accum_done_i   = 1'b0;
        reset_n        = 1'b1;

        run_sample(1, 1'b0, 2, 1'b0, 1'b0);      // inference, T=1
        repeat (2) @(negedge clk);
        run_sample(2, 1'b1, 1, 1'b0, 1'b0);      // training, T=2
        repeat (2) @(negedge clk);
        run_sample(0, 1'b0, 0, 1'b0, 1'b0);      // zero count behaves as one
        repeat (2) @(negedge clk);
        run_sample(2, 1'b1, 0, 1'b1, 1'b0);      // start/accum pulsed inside SURR
        repeat (2) @(negedge clk);
        reset_in_surr();
        run_sample(1, 1'b1, 0, 1'b0, 1'b0);      // start right after reset release
        repeat (2) @(negedge clk);
        run_sample(3, 1'b0, 1, 1'b0, 1'b1);      // config changed mid-sample
        check("final_timestep_cfg_change", 32'(timestep_o), 32'd2);
        repeat (2) @(negedge clk);
        run_sample(255, 1'b0, 0, 1'b0, 1'b0);    // max count, no wrap
        check("final_timestep_max", 32'(timestep_o), 32'd254);
        repeat (5) @(negedge clk);
        check("busy_idle_at_end", 32'(busy_o), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
